// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, 8N1-style framing with a configurable word width.
//
// One start bit (low), BITS_N data bits LSB first, one stop bit (high). Every
// bit is held for CLKS_PER_BIT clock cycles. A word is accepted on a rising
// edge where valid and ready are both high. The line idles high and is driven
// straight from a flip-flop so it never glitches.
//
// Ports
//   clk      : system clock, rising-edge active
//   rst      : asynchronous, active-high reset
//   data_tx  : word to transmit, sampled only at the handshake edge
//   valid    : producer has a word available
//   ready    : transmitter is idle and can take a word this cycle
//   uart_out : serial output line, idle high
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int BITS_N       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BITS_N-1:0] data_tx,
  input  logic              valid,
  output logic              ready,
  output logic              uart_out
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(BITS_N) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS_N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  baud_cnt;
  logic [CNT_W-1:0]  baud_cnt_nxt;
  logic [IDX_W-1:0]  bit_idx;
  logic [IDX_W-1:0]  bit_idx_nxt;
  logic [BITS_N-1:0] shreg;
  logic [BITS_N-1:0] shreg_nxt;
  logic              uart_out_nxt;
  logic              bit_done;

  // Last cycle of the current serial bit.
  assign bit_done = (baud_cnt == CNT_LAST);

  assign ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      uart_out <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shreg    <= shreg_nxt;
      uart_out <= uart_out_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    // The counter restarts at every bit boundary, so it can never wrap inside
    // a bit.
    baud_cnt_nxt = bit_done ? '0 : baud_cnt + CNT_W'(1);
    bit_idx_nxt  = bit_idx;
    shreg_nxt    = shreg;
    uart_out_nxt = uart_out;

    case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        bit_idx_nxt  = '0;
        uart_out_nxt = 1'b1;
        if (valid) begin
          state_nxt    = START;
          shreg_nxt    = data_tx;
          uart_out_nxt = 1'b0;
        end
      end

      START: begin
        if (bit_done) begin
          state_nxt    = DATA;
          bit_idx_nxt  = '0;
          uart_out_nxt = shreg[0];
          shreg_nxt    = shreg >> 1;
        end
      end

      DATA: begin
        if (bit_done) begin
          bit_idx_nxt = bit_idx + IDX_W'(1);
          if (bit_idx == IDX_LAST) begin
            state_nxt    = STOP;
            uart_out_nxt = 1'b1;
          end else begin
            // Shift register always presents the next bit at position 0.
            uart_out_nxt = shreg[0];
            shreg_nxt    = shreg >> 1;
          end
        end
      end

      STOP: begin
        if (bit_done) begin
          state_nxt    = IDLE;
          uart_out_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt    = IDLE;
        uart_out_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: a CLKS_PER_BIT=4 / BITS_N=8 instance for most
// scenarios plus a default-parameter instance for the full-rate frame.
// Expected line values come from a frame model: cycle k after the handshake
// carries bit k/CLKS_PER_BIT of {stop, data[N-1:0], start}.
module tb_uart_tx;

  localparam int C  = 4;
  localparam int N  = 8;
  localparam int CD = 434;
  localparam int ND = 8;
  localparam int FR  = (N + 2) * C;
  localparam int FRD = (ND + 2) * CD;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_tx;
  logic       valid;
  logic       ready;
  logic       uart_out;
  logic [7:0] data_tx_d;
  logic       valid_d;
  logic       ready_d;
  logic       uart_out_d;

  int total = 0;
  int bad   = 0;

  logic obs_out [0:4399];
  logic obs_rdy [0:4399];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(C), .BITS_N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_tx  (data_tx),
    .valid    (valid),
    .ready    (ready),
    .uart_out (uart_out)
  );

  uart_tx dut_def (
    .clk      (clk),
    .rst      (rst),
    .data_tx  (data_tx_d),
    .valid    (valid_d),
    .ready    (ready_d),
    .uart_out (uart_out_d)
  );

  // Reference: line level k cycles after the handshake edge.
  function automatic logic frame_bit(input logic [15:0] w, input int k,
                                     input int cpb, input int nb);
    int b;
    b = k / cpb;
    if (b == 0) return 1'b0;
    if (b <= nb) return w[b-1];
    return 1'b1;
  endfunction

  // Records line and ready on n consecutive falling edges; optionally
  // scrambles data_tx/valid of the small instance each cycle.
  task automatic capture(input int n, input bit def, input bit scramble);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      obs_out[k] = def ? uart_out_d : uart_out;
      obs_rdy[k] = def ? ready_d : ready;
      if (scramble) begin
        data_tx = 8'($urandom);
        valid   = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; data_tx = 8'h00; valid_d = 1'b0; data_tx_d = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (uart_out !== 1'b1) begin bad++; $display("FAIL rst_out got=%b want=1", uart_out); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", ready); end
    total++; if (uart_out_d !== 1'b1) begin bad++; $display("FAIL rst_out_def got=%b want=1", uart_out_d); end
    total++; if (ready_d !== 1'b1) begin bad++; $display("FAIL rst_ready_def got=%b want=1", ready_d); end
    rst = 1'b0;
    capture(100, 1'b0, 1'b0);
    for (int k = 0; k < 100; k++) begin
      total++; if (obs_out[k] !== 1'b1) begin bad++; $display("FAIL idle_out k=%0d got=%b want=1", k, obs_out[k]); end
      total++; if (obs_rdy[k] !== 1'b1) begin bad++; $display("FAIL idle_ready k=%0d got=%b want=1", k, obs_rdy[k]); end
    end
  endtask

  task automatic test_single_a5();
    int low_cnt;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL a5_pre_ready got=%b want=1", ready); end
    data_tx = 8'hA5; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; data_tx = 8'($urandom);
    capture(FR + 1, 1'b0, 1'b0);
    low_cnt = 0;
    for (int k = 0; k < FR; k++) begin
      if (obs_rdy[k] === 1'b0) low_cnt++;
      total++; if (obs_out[k] !== frame_bit(16'h00A5, k, C, N)) begin
        bad++; $display("FAIL a5_bit k=%0d got=%b want=%b", k, obs_out[k], frame_bit(16'h00A5, k, C, N));
      end
    end
    total++; if (low_cnt != FR) begin bad++; $display("FAIL a5_ready_low got=%0d want=%0d", low_cnt, FR); end
    total++; if (obs_rdy[FR] !== 1'b1) begin bad++; $display("FAIL a5_ready_end got=%b want=1", obs_rdy[FR]); end
    total++; if (obs_out[FR] !== 1'b1) begin bad++; $display("FAIL a5_idle_out got=%b want=1", obs_out[FR]); end
  endtask

  task automatic test_back_to_back();
    logic want;
    @(negedge clk);
    data_tx = 8'h7B; valid = 1'b1;
    @(posedge clk); #1;
    data_tx = 8'h22;
    capture(2 * FR + 2, 1'b0, 1'b0);
    valid = 1'b0;
    for (int k = 0; k < 2 * FR + 2; k++) begin
      if (k < FR) want = frame_bit(16'h007B, k, C, N);
      else if (k == FR || k == 2 * FR + 1) want = 1'b1;
      else want = frame_bit(16'h0022, k - FR - 1, C, N);
      total++; if (obs_out[k] !== want) begin bad++; $display("FAIL b2b_bit k=%0d got=%b want=%b", k, obs_out[k], want); end
      want = (k == FR || k == 2 * FR + 1);
      total++; if (obs_rdy[k] !== want) begin bad++; $display("FAIL b2b_ready k=%0d got=%b want=%b", k, obs_rdy[k], want); end
    end
  endtask

  task automatic test_ignore_inputs();
    logic [7:0] d;
    for (int f = 0; f < 4; f++) begin
      d = 8'($urandom);
      @(negedge clk);
      data_tx = d; valid = 1'b1;
      @(posedge clk); #1;
      capture(FR, 1'b0, 1'b1);
      valid = 1'b0;
      for (int k = 0; k < FR; k++) begin
        total++; if (obs_out[k] !== frame_bit({8'h00, d}, k, C, N)) begin
          bad++; $display("FAIL ignore_bit d=%h k=%0d got=%b want=%b", d, k, obs_out[k], frame_bit({8'h00, d}, k, C, N));
        end
      end
      @(negedge clk);
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL ignore_ready_end d=%h got=%b want=1", d, ready); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    @(negedge clk);
    data_tx = 8'h00; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    capture(15, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) begin
      total++; if (obs_out[k] !== 1'b0) begin bad++; $display("FAIL rmid_pre k=%0d got=%b want=0", k, obs_out[k]); end
    end
    @(posedge clk); #2;
    total++; if (uart_out !== 1'b0) begin bad++; $display("FAIL rmid_low15 got=%b want=0", uart_out); end
    rst = 1'b1;
    #1;
    total++; if (uart_out !== 1'b1) begin bad++; $display("FAIL rmid_async_out got=%b want=1", uart_out); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rmid_async_ready got=%b want=1", ready); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    capture(50, 1'b0, 1'b0);
    for (int k = 0; k < 50; k++) begin
      total++; if (obs_out[k] !== 1'b1) begin bad++; $display("FAIL rmid_after k=%0d got=%b want=1", k, obs_out[k]); end
    end
    // Handshake on the very first edge after reset release.
    rst = 1'b1;
    @(negedge clk);
    d = 8'($urandom);
    rst = 1'b0; data_tx = d; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    capture(FR + 1, 1'b0, 1'b0);
    for (int k = 0; k < FR; k++) begin
      total++; if (obs_out[k] !== frame_bit({8'h00, d}, k, C, N)) begin
        bad++; $display("FAIL post_rst_bit d=%h k=%0d got=%b want=%b", d, k, obs_out[k], frame_bit({8'h00, d}, k, C, N));
      end
    end
    total++; if (obs_rdy[FR] !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", obs_rdy[FR]); end
  endtask

  task automatic test_default_rate();
    int low_cnt;
    @(negedge clk);
    total++; if (ready_d !== 1'b1) begin bad++; $display("FAIL def_pre_ready got=%b want=1", ready_d); end
    data_tx_d = 8'h0A; valid_d = 1'b1;
    @(posedge clk); #1;
    valid_d = 1'b0;
    capture(FRD + 1, 1'b1, 1'b0);
    low_cnt = 0;
    for (int k = 0; k < FRD; k++) begin
      if (obs_rdy[k] === 1'b0) low_cnt++;
      total++; if (obs_out[k] !== frame_bit(16'h000A, k, CD, ND)) begin
        bad++; $display("FAIL def_bit k=%0d got=%b want=%b", k, obs_out[k], frame_bit(16'h000A, k, CD, ND));
      end
    end
    total++; if (low_cnt != FRD) begin bad++; $display("FAIL def_frame_len got=%0d want=%0d", low_cnt, FRD); end
    total++; if (obs_rdy[FRD] !== 1'b1) begin bad++; $display("FAIL def_ready_end got=%b want=1", obs_rdy[FRD]); end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_ignore_inputs();
    test_reset_mid_frame();
    test_default_rate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
